// File: rtl/decode_ctrl_pkg.sv
// Shared opcode/ALU constants, FSM state type and the control word
// handed from the decoder to the execute stage.
package decode_ctrl_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [3:0] OP_ADD       = 4'h0;
    localparam logic [3:0] OP_ADDI      = 4'h1;
    localparam logic [3:0] OP_SUB       = 4'h2;
    localparam logic [3:0] OP_SUBI      = 4'h3;
    localparam logic [3:0] OP_AND       = 4'h4;
    localparam logic [3:0] OP_ANDI      = 4'h5;
    localparam logic [3:0] OP_OR        = 4'h6;
    localparam logic [3:0] OP_ORI       = 4'h7;
    localparam logic [3:0] OP_MOV       = 4'h8;
    localparam logic [3:0] OP_BRANZ     = 4'h9;
    localparam logic [3:0] OP_BRAZ      = 4'hA;
    localparam logic [3:0] OP_BRAUNCOND = 4'hB;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALUOP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 3'd3;
    localparam logic [ALUOP_W-1:0] ALU_MOV = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_WAIT_FLAG,
        ST_SQUASH
    } state_t;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_UNCOND,
        BR_ZERO,
        BR_NONZERO
    } br_kind_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               writeenable;
        logic               muximm;
        logic               mov_select;
    } ctrl_word_t;

endpackage

// File: rtl/decode_ctrl_pipe_opcode_decode.sv
// Purely combinational opcode classifier: control word for ALU ops,
// branch kind for branches, illegal flag for everything else.
module opcode_decode
    import decode_ctrl_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_word_t     ctrl,
    output logic           is_branch,
    output br_kind_t       br_kind,
    output logic           illegal
);

    logic [3:0] low;
    logic       upper_set;

    assign low       = opcode[3:0];
    assign upper_set = (opcode >> 4) != '0;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        ctrl      = '0;
        is_branch = 1'b0;
        br_kind   = BR_NONE;
        illegal   = 1'b0;
        if (upper_set) begin
            illegal = 1'b1;
        end else begin
            case (low)
                OP_MOV: begin
                    ctrl.aluop       = ALU_MOV;
                    ctrl.writeenable = 1'b1;
                    ctrl.muximm      = 1'b1;
                    ctrl.mov_select  = 1'b1;
                end
                OP_BRANZ: begin
                    is_branch = 1'b1;
                    br_kind   = BR_NONZERO;
                end
                OP_BRAZ: begin
                    is_branch = 1'b1;
                    br_kind   = BR_ZERO;
                end
                OP_BRAUNCOND: begin
                    is_branch = 1'b1;
                    br_kind   = BR_UNCOND;
                end
                default: begin
                    // Arithmetic/logic pairs: bit 0 selects the immediate form.
                    if (low < OP_MOV) begin
                        ctrl.aluop       = low[3:1];
                        ctrl.writeenable = 1'b1;
                        ctrl.muximm      = low[0];
                    end else begin
                        illegal = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Handshaked decode stage: registers the control word, resolves branches
// against the ALU zero flag and squashes wrong-path fetches afterwards.
module decode_ctrl_pipe
    import decode_ctrl_pkg::*;
#(
    parameter int OPW         = 4,
    parameter int ALUOPW      = 3,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNTW        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              zero_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALUOPW-1:0] aluop,
    output logic              writeenable,
    output logic              muximm,
    output logic              mov_select,
    output logic              br_valid,
    output logic              br_taken,
    output logic              flush,
    output logic              illegal,
    output logic [CNTW-1:0]   stall_cnt
);

    localparam int SQW = $clog2(FLUSH_DEPTH + 1);
    localparam logic [SQW-1:0] SQ_LAST = SQW'(FLUSH_DEPTH - 1);

    state_t         state;
    logic [SQW-1:0] squash_cnt;
    ctrl_word_t     out_word;
    logic           pend_braz;

    ctrl_word_t     dec_ctrl;
    logic           dec_branch;
    br_kind_t       dec_kind;
    logic           dec_illegal;
    logic           accept;
    logic           wait_taken;

    opcode_decode #(.OPW(OPW)) u_decode (
        .opcode    (opcode),
        .ctrl      (dec_ctrl),
        .is_branch (dec_branch),
        .br_kind   (dec_kind),
        .illegal   (dec_illegal)
    );

    // br_valid in RUN only occurs in the resolve cycle of a not-taken branch,
    // where fetch is held off for one cycle before RUN resumes.
    assign in_ready   = ((state == ST_RUN) && !br_valid && (!out_valid || out_ready))
                      || (state == ST_SQUASH);
    assign accept     = in_valid && in_ready;
    assign wait_taken = pend_braz ? zero : !zero;

    // NOTE: state is updated with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            squash_cnt <= '0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            pend_braz  <= 1'b0;
            br_valid   <= 1'b0;
            br_taken   <= 1'b0;
            flush      <= 1'b0;
            illegal    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            br_valid <= 1'b0;
            br_taken <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (accept) begin
                        if (dec_illegal) begin
                            illegal <= 1'b1;
                        end else if (dec_branch) begin
                            if (dec_kind == BR_UNCOND) begin
                                br_valid   <= 1'b1;
                                br_taken   <= 1'b1;
                                flush      <= 1'b1;
                                squash_cnt <= '0;
                                state      <= ST_SQUASH;
                            end else begin
                                pend_braz <= (dec_kind == BR_ZERO);
                                state     <= ST_WAIT_FLAG;
                            end
                        end else begin
                            out_valid <= 1'b1;
                            out_word  <= dec_ctrl;
                        end
                    end
                end

                ST_WAIT_FLAG: begin
                    if (zero_valid) begin
                        br_valid <= 1'b1;
                        br_taken <= wait_taken;
                        if (wait_taken) begin
                            flush      <= 1'b1;
                            squash_cnt <= '0;
                            state      <= ST_SQUASH;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + CNTW'(1);
                    end
                end

                ST_SQUASH: begin
                    if (squash_cnt == SQ_LAST) begin
                        flush <= 1'b0;
                        state <= ST_RUN;
                    end else begin
                        squash_cnt <= squash_cnt + SQW'(1);
                    end
                end

                default: state <= ST_RUN;
            endcase
        end
    end

    assign aluop       = ALUOPW'(out_word.aluop);
    assign writeenable = out_word.writeenable;
    assign muximm      = out_word.muximm;
    assign mov_select  = out_word.mov_select;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Scoreboard bench for decode_ctrl_pipe: the driver pushes expected beats and
// branch outcomes from an opcode-level model, a negedge monitor pops and compares.
module tb_decode_ctrl_pipe;

    localparam int OPW         = 4;
    localparam int ALUOPW      = 3;
    localparam int FLUSH_DEPTH = 2;
    localparam int CNTW        = 8;
    localparam int STALL_MAX   = (1 << CNTW) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [OPW-1:0]    opcode;
    logic              zero;
    logic              zero_valid;
    logic              out_valid;
    logic              out_ready;
    logic [ALUOPW-1:0] aluop;
    logic              writeenable;
    logic              muximm;
    logic              mov_select;
    logic              br_valid;
    logic              br_taken;
    logic              flush;
    logic              illegal;
    logic [CNTW-1:0]   stall_cnt;

    decode_ctrl_pipe #(
        .OPW(OPW), .ALUOPW(ALUOPW), .FLUSH_DEPTH(FLUSH_DEPTH), .CNTW(CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .zero        (zero),
        .zero_valid  (zero_valid),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .aluop       (aluop),
        .writeenable (writeenable),
        .muximm      (muximm),
        .mov_select  (mov_select),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .flush       (flush),
        .illegal     (illegal),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    // Opcode-level model state.
    logic [5:0] exp_q[$];
    bit         br_q[$];
    int         flush_left  = 0;
    bit         wait_mode   = 1'b0;
    bit         exp_illegal = 1'b0;
    int         exp_stall   = 0;
    bit         rand_ready  = 1'b0;
    bit         mon_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {aluop, writeenable, muximm, mov_select} straight from the ISA table.
    function automatic logic [5:0] model_word(input int op);
        if (op == 8) return {3'd4, 1'b1, 1'b1, 1'b1};
        return {3'(op / 2), 1'b1, 1'(op % 2), 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (flush_left > 0) flush_left--;
        if (rand_ready) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic send(input int op);
        bit drop = 1'b0;
        bit done = 1'b0;
        in_valid = 1'b1;
        opcode   = 4'(op);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                drop = (flush_left > 0);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: opcode %0h never accepted", op);
        end else if (!drop) begin
            if (op <= 8) begin
                exp_q.push_back(model_word(op));
            end else if (op == 11) begin
                br_q.push_back(1'b1);
                flush_left = FLUSH_DEPTH;
            end else if (op == 9 || op == 10) begin
                wait_mode = 1'b1;
            end else begin
                exp_illegal = 1'b1;
            end
        end
    endtask

    // Drives the zero flag for a pending conditional branch; legal opcodes are
    // offered meanwhile and must not be accepted.
    task automatic resolve(input int delay, input bit zv, input bit is_braz);
        bit taken;
        for (int i = 0; i < delay; i++) begin
            zero_valid = 1'b0;
            zero       = 1'($urandom_range(1));
            in_valid   = 1'b1;
            opcode     = 4'($urandom_range(8));
            tick();
            if (exp_stall < STALL_MAX) exp_stall++;
        end
        zero_valid = 1'b1;
        zero       = zv;
        tick();
        zero_valid = 1'b0;
        in_valid   = 1'b0;
        wait_mode  = 1'b0;
        taken      = is_braz ? zv : !zv;
        br_q.push_back(taken);
        if (taken) flush_left = FLUSH_DEPTH;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_aluop"}, aluop, 0);
        check({tag, "_writeenable"}, writeenable, 0);
        check({tag, "_muximm"}, muximm, 0);
        check({tag, "_mov_select"}, mov_select, 0);
        check({tag, "_br_valid"}, br_valid, 0);
        check({tag, "_br_taken"}, br_taken, 0);
        check({tag, "_flush"}, flush, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic reset_mid(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        br_q.delete();
        flush_left  = 0;
        wait_mode   = 1'b0;
        exp_illegal = 1'b0;
        exp_stall   = 0;
        in_valid    = 1'b0;
        zero_valid  = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: every output compared against the model once per cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_rdy = (flush_left > 0)
                   || (!wait_mode && br_q.size() == 0 && (exp_q.size() == 0 || out_ready));
            check("in_ready", in_ready, mon_rdy);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                check("ctrl_word", {aluop, writeenable, muximm, mov_select}, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
            check("br_valid", br_valid, br_q.size() != 0);
            if (br_valid && br_q.size() != 0) begin
                check("br_taken", br_taken, br_q[0]);
                void'(br_q.pop_front());
            end
            check("flush", flush, flush_left > 0);
            check("illegal", illegal, exp_illegal);
            check("stall_cnt", stall_cnt, exp_stall);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int op;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        opcode     = '0;
        zero       = 1'b0;
        zero_valid = 1'b0;
        out_ready  = 1'b1;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();

        // Back-to-back stream of all ALU opcodes.
        c0 = cyc;
        for (int i = 0; i <= 8; i++) send(i);
        check("stream_cycles", cyc - c0, 9);
        tick();

        // Back-pressure: output held, no accept while stalled.
        out_ready = 1'b0;
        send(0);
        in_valid = 1'b1;
        opcode   = 4'h1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        send(1);
        tick();

        // BRAZ with 4 stall cycles, taken; two opcodes squashed.
        send(10);
        resolve(4, 1'b1, 1'b1);
        check("stall_after_braz", stall_cnt, 4);
        send(3);
        send(8);
        tick();

        // BRANZ with zero already valid at accept (ignored), not taken.
        zero_valid = 1'b1;
        zero       = 1'b1;
        send(9);
        resolve(0, 1'b1, 1'b0);
        c0 = cyc;
        send(5);
        check("branz_resume_cycles", cyc - c0, 2);
        tick();

        // Illegal opcode is sticky across legal traffic.
        send(13);
        for (int i = 0; i < 10; i++) send($urandom_range(8));
        tick();
        check("illegal_sticky", illegal, 1);

        // Asynchronous reset mid-WAIT_FLAG and mid-SQUASH.
        send(10);
        zero_valid = 1'b0;
        tick();
        exp_stall++;
        tick();
        exp_stall++;
        reset_mid("rst_wait");
        send(11);
        check("squash_before_rst", flush, 1);
        reset_mid("rst_squash");
        send(2);
        tick();

        // Randomised mix with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(99);
            if (r < 60) begin
                send($urandom_range(8));
            end else if (r < 65) begin
                send(12 + $urandom_range(3));
            end else if (r < 75) begin
                send(11);
            end else begin
                op         = 9 + $urandom_range(1);
                zero_valid = 1'($urandom_range(1));
                zero       = 1'($urandom_range(1));
                send(op);
                zero_valid = 1'b0;
                if (wait_mode) resolve($urandom_range(5), 1'($urandom_range(1)), op == 10);
            end
        end

        // Stall counter saturation.
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        send(9);
        resolve(STALL_MAX + 5, 1'b0, 1'b0);
        check("stall_saturated", stall_cnt, STALL_MAX);

        for (int i = 0; i < 5; i++) tick();
        check("beats_drained", exp_q.size(), 0);
        check("branches_drained", br_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
